// File: rtl/wb_regfile_pkg.sv
// Shared register-file constants: bus widths, reset word, null register address
// and enable encodings used by the write-back and decode stages.
package wb_regfile_pkg;

    localparam int RegBusWidth     = 32;
    localparam int RegAddrBusWidth = 5;
    localparam int RegNum          = 32;

    localparam logic [RegBusWidth-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBusWidth-1:0] NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO special register pair; both halves always load together and are
// visible only after the write edge.
module hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RegBusWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= DATA_W'(ZeroWord);
            lo_reg <= DATA_W'(ZeroWord);
        end else if (we == WriteEnable) begin
            hi_reg <= hi_i;
            lo_reg <= lo_i;
        end
    end

    assign hi_o = hi_reg;
    assign lo_o = lo_reg;

endmodule

// File: rtl/wb_regfile.sv
// General-purpose register file with two combinational read ports that forward
// same-cycle write-back data, plus the HI/LO pair.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int  DATA_W  = RegBusWidth,
    parameter int  REG_NUM = RegNum,
    localparam int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // Flops rather than RAM: reset must clear every entry at once.
    logic [DATA_W-1:0] gpr_reg [REG_NUM];
    logic              gpr_we;

    assign gpr_we = (we == WriteEnable) && (waddr != ADDR_W'(NOPRegAddr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr_reg[i] <= DATA_W'(ZeroWord);
            end
        end else if (gpr_we) begin
            gpr_reg[waddr] <= wdata;
        end
    end

    logic              re_vec    [2];
    logic [ADDR_W-1:0] raddr_vec [2];

    assign re_vec[0]    = re1;
    assign re_vec[1]    = re2;
    assign raddr_vec[0] = raddr1;
    assign raddr_vec[1] = raddr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_next;

            // Forwarding covers a producer three instructions ahead, which is
            // in write-back while the consumer is still decoding.
            always_comb begin
                rd_next = DATA_W'(ZeroWord);
                if (rst || re_vec[gi] != ReadEnable) begin
                    rd_next = DATA_W'(ZeroWord);
                end else if (raddr_vec[gi] == ADDR_W'(NOPRegAddr)) begin
                    rd_next = DATA_W'(ZeroWord);
                end else if (gpr_we && raddr_vec[gi] == waddr) begin
                    rd_next = wdata;
                end else begin
                    rd_next = gpr_reg[raddr_vec[gi]];
                end
            end

            if (gi == 0) begin : g_p1
                assign rdata1 = rd_next;
            end else begin : g_p2
                assign rdata2 = rd_next;
            end
        end
    endgenerate

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .we   (whilo),
        .hi_i (hi_i),
        .lo_i (lo_i),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

endmodule
